id_ex_alu_issue: RTL and testbench

// - ID->EX issue stage: decodes the MIPS instruction in ID and produces the 4-bit aluc code and the a/b operands the EX-stage ALU consumes.
// - Holds them in the ID/EX pipeline register, with stall, flush and load-use bubble insertion.
// - Sits between the register-file read in ID and the combinational ALU in EX.

---
 rtl/id_ex_alu_issue_if.sv | 38 +++
 rtl/id_ex_alu_issue.sv | 203 ++++++++++++++++++++
 tb/tb_id_ex_alu_issue.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_alu_issue_if.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_alu_issue_if
// Purpose  : ID->EX issue bundle: ID operands and controls in, EX ALU fields out.
// Revision : 1.0
// ============================================================================
interface id_ex_alu_issue_if;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_rs_val;
    logic [31:0] id_rt_val;
    logic        ex_hold;
    logic        flush;
    logic        lu_stall;
    logic        ex_valid;
    logic [3:0]  ex_aluc;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [4:0]  ex_rd;
    logic        ex_wreg;
    logic        ex_m2reg;
    logic        ex_wmem;
    logic [31:0] ex_store_val;
    logic        ex_illegal;

    modport master (
        output id_valid, id_inst, id_rs_val, id_rt_val, ex_hold, flush,
        input  lu_stall, ex_valid, ex_aluc, ex_a, ex_b, ex_rd,
               ex_wreg, ex_m2reg, ex_wmem, ex_store_val, ex_illegal
    );

    modport slave (
        input  id_valid, id_inst, id_rs_val, id_rt_val, ex_hold, flush,
        output lu_stall, ex_valid, ex_aluc, ex_a, ex_b, ex_rd,
               ex_wreg, ex_m2reg, ex_wmem, ex_store_val, ex_illegal
    );
endinterface
`default_nettype wire

// File: rtl/id_ex_alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_alu_issue
// Purpose  : MIPS ID decode to ALU aluc/operands, held in the ID/EX register
//            with stall, flush and load-use bubble insertion.
//            Optional macro ISSUE_SLT_EN enables slt/sltu/slti/sltiu.
// Revision : 1.0
// ============================================================================
module id_ex_alu_issue #(
    parameter logic [3:0] NOP_ALUC = 4'b0000
) (
    input  logic              clk,
    input  logic              rst,
    id_ex_alu_issue_if.slave  bus_if
);

    localparam logic [3:0] c_ALUC_ADD = 4'b0000;
    localparam logic [3:0] c_ALUC_SUB = 4'b0100;
    localparam logic [3:0] c_ALUC_AND = 4'b0001;
    localparam logic [3:0] c_ALUC_OR  = 4'b0101;
    localparam logic [3:0] c_ALUC_XOR = 4'b0010;
    localparam logic [3:0] c_ALUC_LUI = 4'b0110;
    localparam logic [3:0] c_ALUC_SLL = 4'b0011;
    localparam logic [3:0] c_ALUC_SRL = 4'b0111;
    localparam logic [3:0] c_ALUC_SRA = 4'b1111;
`ifdef ISSUE_SLT_EN
    localparam logic [3:0] c_ALUC_SLT = 4'b1011;
`endif

    typedef struct packed {
        logic        valid;
        logic [3:0]  aluc;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic [31:0] store_val;
        logic        illegal;
    } ex_t;

    ex_t         ex_q;
    ex_t         ex_d;
    ex_t         w_dec;
    ex_t         w_bubble;

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_sa;
    logic [31:0] w_simm;
    logic [31:0] w_zimm;
    logic        w_legal;
    logic        w_use_rs;
    logic        w_use_rt;
    logic        w_writes;
    logic        w_flip;
    logic [4:0]  w_dest;
    logic        w_src_hit;
    logic        w_hazard;

    assign w_op    = bus_if.id_inst[31:26];
    assign w_rs    = bus_if.id_inst[25:21];
    assign w_rt    = bus_if.id_inst[20:16];
    assign w_rd    = bus_if.id_inst[15:11];
    assign w_sa    = bus_if.id_inst[10:6];
    assign w_funct = bus_if.id_inst[5:0];
    assign w_simm  = {{16{bus_if.id_inst[15]}}, bus_if.id_inst[15:0]};
    assign w_zimm  = {16'd0, bus_if.id_inst[15:0]};

    always_comb begin
        w_bubble      = '0;
        w_bubble.aluc = NOP_ALUC;
    end

    always_comb begin
        w_dec       = '0;
        w_dec.valid = 1'b1;
        w_dec.aluc  = NOP_ALUC;
        w_dec.a     = bus_if.id_rs_val;
        w_dec.b     = bus_if.id_rt_val;
        w_legal     = 1'b0;
        w_use_rs    = 1'b0;
        w_use_rt    = 1'b0;
        w_writes    = 1'b0;
        w_flip      = 1'b0;
        w_dest      = 5'd0;
        case (w_op)
            6'b000000: begin
                w_use_rs = 1'b1;
                w_use_rt = 1'b1;
                w_writes = 1'b1;
                w_dest   = w_rd;
                case (w_funct)
                    6'b100000, 6'b100001: begin w_legal = 1'b1; w_dec.aluc = c_ALUC_ADD; end
                    6'b100010, 6'b100011: begin w_legal = 1'b1; w_dec.aluc = c_ALUC_SUB; end
                    6'b100100: begin w_legal = 1'b1; w_dec.aluc = c_ALUC_AND; end
                    6'b100101: begin w_legal = 1'b1; w_dec.aluc = c_ALUC_OR;  end
                    6'b100110: begin w_legal = 1'b1; w_dec.aluc = c_ALUC_XOR; end
                    6'b000000, 6'b000010, 6'b000011: begin
                        // Shifts take the amount from the sa field and only read rt
                        w_legal  = 1'b1;
                        w_use_rs = 1'b0;
                        w_dec.a  = {27'd0, w_sa};
                        w_dec.aluc = (w_funct == 6'b000000) ? c_ALUC_SLL :
                                     (w_funct == 6'b000010) ? c_ALUC_SRL : c_ALUC_SRA;
                    end
`ifdef ISSUE_SLT_EN
                    6'b101010: begin w_legal = 1'b1; w_dec.aluc = c_ALUC_SLT; end
                    6'b101011: begin w_legal = 1'b1; w_dec.aluc = c_ALUC_SLT; w_flip = 1'b1; end
`endif
                    default: ;
                endcase
            end
            6'b001000, 6'b001001: begin
                w_legal = 1'b1; w_use_rs = 1'b1; w_writes = 1'b1; w_dest = w_rt;
                w_dec.aluc = c_ALUC_ADD; w_dec.b = w_simm;
            end
            6'b001100, 6'b001101, 6'b001110: begin
                w_legal = 1'b1; w_use_rs = 1'b1; w_writes = 1'b1; w_dest = w_rt;
                w_dec.b = w_zimm;
                w_dec.aluc = (w_op == 6'b001100) ? c_ALUC_AND :
                             (w_op == 6'b001101) ? c_ALUC_OR  : c_ALUC_XOR;
            end
            6'b001111: begin
                w_legal = 1'b1; w_writes = 1'b1; w_dest = w_rt;
                w_dec.aluc = c_ALUC_LUI; w_dec.b = w_zimm;
            end
`ifdef ISSUE_SLT_EN
            6'b001010, 6'b001011: begin
                w_legal = 1'b1; w_use_rs = 1'b1; w_writes = 1'b1; w_dest = w_rt;
                w_dec.aluc = c_ALUC_SLT; w_dec.b = w_simm;
                w_flip = (w_op == 6'b001011);
            end
`endif
            6'b100011: begin
                w_legal = 1'b1; w_use_rs = 1'b1; w_writes = 1'b1; w_dest = w_rt;
                w_dec.aluc = c_ALUC_ADD; w_dec.b = w_simm; w_dec.m2reg = 1'b1;
            end
            6'b101011: begin
                w_legal = 1'b1; w_use_rs = 1'b1; w_use_rt = 1'b1;
                w_dec.aluc = c_ALUC_ADD; w_dec.b = w_simm; w_dec.wmem = 1'b1;
                w_dec.store_val = bus_if.id_rt_val;
            end
            6'b000100, 6'b000101: begin
                w_legal = 1'b1; w_use_rs = 1'b1; w_use_rt = 1'b1;
                w_dec.aluc = c_ALUC_SUB;
            end
            default: ;
        endcase
        w_dec.rd   = w_dest;
        w_dec.wreg = w_writes & (w_dest != 5'd0);
        // Unsigned compare reuses the signed path by biasing both operands
        if (w_flip) begin
            w_dec.a[31] = ~w_dec.a[31];
            w_dec.b[31] = ~w_dec.b[31];
        end
    end

    assign w_src_hit = (w_use_rs & (w_rs == ex_q.rd)) | (w_use_rt & (w_rt == ex_q.rd));
    assign w_hazard  = bus_if.id_valid & w_legal & ex_q.valid & ex_q.m2reg &
                       (ex_q.rd != 5'd0) & w_src_hit;

    assign bus_if.lu_stall = w_hazard & ~bus_if.ex_hold;

    always_comb begin
        ex_d = ex_q;
        if (bus_if.flush) begin
            ex_d = w_bubble;
        end else if (!bus_if.ex_hold) begin
            if (w_hazard || !bus_if.id_valid || !w_legal) begin
                ex_d         = w_bubble;
                ex_d.illegal = bus_if.id_valid & ~w_legal;
            end else begin
                ex_d = w_dec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= w_bubble;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign bus_if.ex_valid     = ex_q.valid;
    assign bus_if.ex_aluc      = ex_q.aluc;
    assign bus_if.ex_a         = ex_q.a;
    assign bus_if.ex_b         = ex_q.b;
    assign bus_if.ex_rd        = ex_q.rd;
    assign bus_if.ex_wreg      = ex_q.wreg;
    assign bus_if.ex_m2reg     = ex_q.m2reg;
    assign bus_if.ex_wmem      = ex_q.wmem;
    assign bus_if.ex_store_val = ex_q.store_val;
    assign bus_if.ex_illegal   = ex_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_alu_issue
// Purpose  : Self-checking bench for id_ex_alu_issue: directed literals plus
//            randomized traffic against an instruction-level reference model.
// Revision : 1.0
// ============================================================================
module tb_id_ex_alu_issue;

    localparam logic [3:0] NOP = 4'b0000;

    typedef struct packed {
        logic        valid;
        logic [3:0]  aluc;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic [31:0] sv;
        logic        ill;
    } ex_s;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    bit   chk_en = 1'b0;
    ex_s  m;

    always #5 clk = ~clk;

    id_ex_alu_issue_if bus_if ();

    id_ex_alu_issue #(.NOP_ALUC(NOP)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus_if)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic ex_s bubble();
        ex_s e;
        e      = '0;
        e.aluc = NOP;
        return e;
    endfunction

    // Instruction-level semantics: what EX must see for one ID instruction.
    function automatic void ref_decode(input logic [31:0] inst, input logic [31:0] rsv,
                                       input logic [31:0] rtv, output ex_s e, output bit legal,
                                       output logic [4:0] s1, output logic [4:0] s2);
        int          op   = int'(inst[31:26]);
        int          fn   = int'(inst[5:0]);
        logic [4:0]  rs   = inst[25:21];
        logic [4:0]  rt   = inst[20:16];
        logic [31:0] simm = {{16{inst[15]}}, inst[15:0]};
        logic [31:0] zimm = {16'd0, inst[15:0]};
        e = bubble(); e.valid = 1'b1; legal = 1'b1; s1 = 5'd0; s2 = 5'd0;
        e.a = rsv;
        if (op == 0) begin
            e.b = rtv; e.rd = inst[15:11]; e.wreg = 1'b1; s1 = rs; s2 = rt;
            case (fn)
                32, 33: e.aluc = 4'd0;
                34, 35: e.aluc = 4'd4;
                36:     e.aluc = 4'd1;
                37:     e.aluc = 4'd5;
                38:     e.aluc = 4'd2;
                0:      begin e.aluc = 4'd3;  e.a = 32'(inst[10:6]); s1 = 5'd0; end
                2:      begin e.aluc = 4'd7;  e.a = 32'(inst[10:6]); s1 = 5'd0; end
                3:      begin e.aluc = 4'd15; e.a = 32'(inst[10:6]); s1 = 5'd0; end
`ifdef ISSUE_SLT_EN
                42:     e.aluc = 4'd11;
                43:     begin e.aluc = 4'd11; e.a = rsv ^ 32'h8000_0000; e.b = rtv ^ 32'h8000_0000; end
`endif
                default: legal = 1'b0;
            endcase
        end else begin
            s1 = rs;
            case (op)
                8, 9:   begin e.aluc = 4'd0; e.b = simm; e.rd = rt; e.wreg = 1'b1; end
                12:     begin e.aluc = 4'd1; e.b = zimm; e.rd = rt; e.wreg = 1'b1; end
                13:     begin e.aluc = 4'd5; e.b = zimm; e.rd = rt; e.wreg = 1'b1; end
                14:     begin e.aluc = 4'd2; e.b = zimm; e.rd = rt; e.wreg = 1'b1; end
                15:     begin e.aluc = 4'd6; e.b = zimm; e.rd = rt; e.wreg = 1'b1; s1 = 5'd0; end
`ifdef ISSUE_SLT_EN
                10:     begin e.aluc = 4'd11; e.b = simm; e.rd = rt; e.wreg = 1'b1; end
                11:     begin e.aluc = 4'd11; e.a = rsv ^ 32'h8000_0000;
                              e.b = simm ^ 32'h8000_0000; e.rd = rt; e.wreg = 1'b1; end
`endif
                35:     begin e.aluc = 4'd0; e.b = simm; e.rd = rt; e.wreg = 1'b1; e.m2reg = 1'b1; end
                43:     begin e.aluc = 4'd0; e.b = simm; e.wmem = 1'b1; e.sv = rtv; s2 = rt; end
                4, 5:   begin e.aluc = 4'd4; e.b = rtv; s2 = rt; end
                default: legal = 1'b0;
            endcase
        end
        if (e.rd == 5'd0) e.wreg = 1'b0;
    endfunction

    function automatic bit ref_hazard(input ex_s cur);
        ex_s e; bit legal; logic [4:0] s1; logic [4:0] s2;
        ref_decode(bus_if.id_inst, bus_if.id_rs_val, bus_if.id_rt_val, e, legal, s1, s2);
        return bus_if.id_valid && legal && cur.valid && cur.m2reg && cur.rd != 5'd0 &&
               (s1 == cur.rd || s2 == cur.rd);
    endfunction

    initial m = bubble();

    always @(posedge clk) begin : model
        ex_s e; bit legal; bit haz; logic [4:0] s1; logic [4:0] s2;
        ref_decode(bus_if.id_inst, bus_if.id_rs_val, bus_if.id_rt_val, e, legal, s1, s2);
        haz = ref_hazard(m);
        if (rst || bus_if.flush) begin
            m = bubble();
        end else if (!bus_if.ex_hold) begin
            if (haz || !bus_if.id_valid || !legal) begin
                m     = bubble();
                m.ill = bus_if.id_valid && !legal;
            end else begin
                m = e;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid",     32'(bus_if.ex_valid),  32'(m.valid));
            chk("aluc",      32'(bus_if.ex_aluc),   32'(m.aluc));
            chk("a",         bus_if.ex_a,           m.a);
            chk("b",         bus_if.ex_b,           m.b);
            chk("rd",        32'(bus_if.ex_rd),     32'(m.rd));
            chk("wreg",      32'(bus_if.ex_wreg),   32'(m.wreg));
            chk("m2reg",     32'(bus_if.ex_m2reg),  32'(m.m2reg));
            chk("wmem",      32'(bus_if.ex_wmem),   32'(m.wmem));
            chk("store_val", bus_if.ex_store_val,   m.sv);
            chk("illegal",   32'(bus_if.ex_illegal), 32'(m.ill));
            chk("lu_stall",  32'(bus_if.lu_stall),  32'(ref_hazard(m) && !bus_if.ex_hold));
        end
    end

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] rsv,
                         input logic [31:0] rtv, input logic hold, input logic fl);
        bus_if.id_valid  = v;
        bus_if.id_inst   = inst;
        bus_if.id_rs_val = rsv;
        bus_if.id_rt_val = rtv;
        bus_if.ex_hold   = hold;
        bus_if.flush     = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] w = $urandom;
        logic [5:0]  op = 6'd0;
        logic [5:0]  fn = w[5:0];
        int          k  = $urandom_range(0, 19);
        w[25:21] = 5'($urandom_range(0, 3));
        w[20:16] = 5'($urandom_range(0, 3));
        w[15:11] = 5'($urandom_range(0, 3));
        case (k)
            0, 1, 2, 3, 4: fn = 6'(32 + $urandom_range(0, 6));
            5, 6:   fn = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'(1 + $urandom_range(1, 2));
            7:      fn = 6'(42 + $urandom_range(0, 1));
            8:      fn = w[5:0];
            9:      begin op = 6'd15; w[25:21] = 5'd0; end
            10, 11, 12: op = 6'd35;
            13:     op = 6'd43;
            14:     op = 6'(4 + $urandom_range(0, 1));
            15:     op = 6'(8 + $urandom_range(0, 1));
            16:     op = 6'(12 + $urandom_range(0, 2));
            17:     op = 6'(10 + $urandom_range(0, 1));
            18:     op = 6'($urandom_range(0, 63));
            default: return $urandom;
        endcase
        w[31:26] = op;
        if (op == 6'd0) w[5:0] = fn;
        return w;
    endfunction

    initial begin
        bit stall;
        drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        chk_en = 1'b1;
        rst    = 1'b0;
        chk("rst_valid", 32'(bus_if.ex_valid), 32'd0);
        chk("rst_aluc",  32'(bus_if.ex_aluc),  32'(NOP));
        chk("rst_a",     bus_if.ex_a,          32'd0);
        chk("rst_wreg",  32'(bus_if.ex_wreg),  32'd0);
        chk("rst_stall", 32'(bus_if.lu_stall), 32'd0);

        drive(1'b1, 32'h00221820, 32'd5, 32'd7, 1'b0, 1'b0);
        tick();
        chk("add_aluc",  32'(bus_if.ex_aluc),  32'h0);
        chk("add_a",     bus_if.ex_a,          32'd5);
        chk("add_b",     bus_if.ex_b,          32'd7);
        chk("add_rd",    32'(bus_if.ex_rd),    32'd3);
        chk("add_wreg",  32'(bus_if.ex_wreg),  32'd1);
        chk("add_valid", 32'(bus_if.ex_valid), 32'd1);

        drive(1'b1, 32'h00022103, 32'd0, 32'h8000_0000, 1'b0, 1'b0);
        tick();
        chk("sra_aluc", 32'(bus_if.ex_aluc), 32'hF);
        chk("sra_a",    bus_if.ex_a,         32'd4);
        chk("sra_b",    bus_if.ex_b,         32'h8000_0000);
        chk("sra_rd",   32'(bus_if.ex_rd),   32'd4);

        drive(1'b1, 32'h3405FFFF, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        chk("ori_b", bus_if.ex_b, 32'h0000_FFFF);
        drive(1'b1, 32'h2005FFFF, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        chk("addi_b", bus_if.ex_b, 32'hFFFF_FFFF);

        drive(1'b1, 32'h8C220000, 32'h100, 32'd0, 1'b0, 1'b0);
        tick();
        chk("lw_m2reg", 32'(bus_if.ex_m2reg), 32'd1);
        chk("lw_rd",    32'(bus_if.ex_rd),    32'd2);
        drive(1'b1, 32'h00421820, 32'd9, 32'd9, 1'b0, 1'b0);
        #1;
        chk("lu_stall_hit", 32'(bus_if.lu_stall), 32'd1);
        tick();
        chk("lu_bubble_valid", 32'(bus_if.ex_valid), 32'd0);
        chk("lu_stall_clear",  32'(bus_if.lu_stall), 32'd0);
        tick();
        chk("lu_issue_valid", 32'(bus_if.ex_valid), 32'd1);
        chk("lu_issue_a",     bus_if.ex_a,          32'd9);

        drive(1'b1, 32'h00221820, 32'd11, 32'd13, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h2005FFFF, 32'd0, 32'd0, 1'b1, 1'b0);
        repeat (3) begin
            tick();
            chk("hold_a",    bus_if.ex_a,           32'd11);
            chk("hold_b",    bus_if.ex_b,           32'd13);
            chk("hold_aluc", 32'(bus_if.ex_aluc),   32'h0);
        end
        drive(1'b1, 32'h2005FFFF, 32'd0, 32'd0, 1'b1, 1'b1);
        tick();
        chk("flush_valid", 32'(bus_if.ex_valid), 32'd0);
        chk("flush_a",     bus_if.ex_a,          32'd0);

        drive(1'b1, 32'hFC000000, 32'd1, 32'd2, 1'b0, 1'b0);
        tick();
        chk("ill_flag",  32'(bus_if.ex_illegal), 32'd1);
        chk("ill_valid", 32'(bus_if.ex_valid),   32'd0);
        drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        chk("ill_clear", 32'(bus_if.ex_illegal), 32'd0);

        drive(1'b1, 32'h2005FFFF, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        chk("pre_rst_valid", 32'(bus_if.ex_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", 32'(bus_if.ex_valid), 32'd0);
        chk("mid_rst_b",     bus_if.ex_b,          32'd0);
        chk("mid_rst_wreg",  32'(bus_if.ex_wreg),  32'd0);

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            stall = bus_if.lu_stall;
            @(posedge clk);
            #2;
            rst            = ($urandom_range(0, 199) == 0);
            bus_if.ex_hold = ($urandom_range(0, 6) == 0);
            bus_if.flush   = ($urandom_range(0, 19) == 0);
            if (!stall) begin
                bus_if.id_valid  = ($urandom_range(0, 7) != 0);
                bus_if.id_inst   = rand_inst();
                bus_if.id_rs_val = $urandom;
                bus_if.id_rt_val = $urandom;
            end
        end
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
